// File: rtl/tm_cfg_pkg.sv
// Shared constants and state encoding for the Tsetlin-machine exclude-mask loader.
package tm_cfg_pkg;

  localparam int         NUM_CLAUSES    = 12;
  localparam int         MASK_W         = 18;
  localparam logic [7:0] HEADER         = 8'hA5;
  localparam int         BYTES_PER_WORD = 3;
  localparam int         PAYLOAD_BYTES  = NUM_CLAUSES * BYTES_PER_WORD;

  typedef enum logic [1:0] {
    IDLE,
    PAYLOAD,
    CHECKSUM,
    DONE
  } state_e;

endpackage

// File: rtl/tm_exclude_loader.sv
// Byte-stream loader for the 12 clause exclude masks: frames are assembled in a
// shadow bank, checked (XOR + reserved bits) and committed atomically to the active bank.
module tm_exclude_loader #(
  parameter int         NUM_CLAUSES = tm_cfg_pkg::NUM_CLAUSES,
  parameter int         MASK_W      = tm_cfg_pkg::MASK_W,
  parameter logic [7:0] HEADER      = tm_cfg_pkg::HEADER
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        in_data,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic              abort,
  output logic [MASK_W-1:0] exclude_state1,
  output logic [MASK_W-1:0] exclude_state2,
  output logic [MASK_W-1:0] exclude_state3,
  output logic [MASK_W-1:0] exclude_state4,
  output logic [MASK_W-1:0] exclude_state5,
  output logic [MASK_W-1:0] exclude_state6,
  output logic [MASK_W-1:0] exclude_state7,
  output logic [MASK_W-1:0] exclude_state8,
  output logic [MASK_W-1:0] exclude_state9,
  output logic [MASK_W-1:0] exclude_state10,
  output logic [MASK_W-1:0] exclude_state11,
  output logic [MASK_W-1:0] exclude_state12,
  output logic              cfg_valid,
  output logic              commit,
  output logic              frame_err,
  output logic              busy
);
  import tm_cfg_pkg::*;

  localparam int WORD_W = $clog2(NUM_CLAUSES);
  localparam logic [WORD_W-1:0] LAST_WORD = WORD_W'(NUM_CLAUSES - 1);
  localparam logic [1:0]        LAST_BYTE = 2'(BYTES_PER_WORD - 1);

  state_e              state_q, state_d;
  logic [WORD_W-1:0]   word_q, word_d;
  logic [1:0]          byte_q, byte_d;
  logic [7:0]          xor_q, xor_d;
  logic                rsv_err_q, rsv_err_d;
  logic                cfg_valid_q, cfg_valid_d;
  logic                commit_q, commit_d;
  logic                frame_err_q, frame_err_d;
  logic [MASK_W-1:0]   shadow_q [NUM_CLAUSES];
  logic [MASK_W-1:0]   shadow_d [NUM_CLAUSES];
  logic [MASK_W-1:0]   active_q [NUM_CLAUSES];
  logic [MASK_W-1:0]   active_d [NUM_CLAUSES];
  logic                accept;

  // Ready is a pure state decode so the host sees no combinational loop through in_valid.
  assign in_ready = (state_q != DONE);
  assign busy     = (state_q != IDLE);
  assign accept   = in_valid && in_ready;

  always_comb begin
    state_d     = state_q;
    word_d      = word_q;
    byte_d      = byte_q;
    xor_d       = xor_q;
    rsv_err_d   = rsv_err_q;
    commit_d    = 1'b0;
    frame_err_d = 1'b0;
    shadow_d    = shadow_q;
    active_d    = active_q;

    if (abort) begin
      state_d = IDLE;
    end else begin
      case (state_q)
        IDLE: begin
          if (accept && in_data == HEADER) begin
            state_d   = PAYLOAD;
            word_d    = '0;
            byte_d    = '0;
            xor_d     = '0;
            rsv_err_d = 1'b0;
          end
        end
        PAYLOAD: begin
          if (accept) begin
            xor_d = xor_q ^ in_data;
            case (byte_q)
              2'd0: begin
                shadow_d[word_q][MASK_W-1:16] = in_data[MASK_W-17:0];
                if (|in_data[7:MASK_W-16]) rsv_err_d = 1'b1;
              end
              2'd1:    shadow_d[word_q][15:8] = in_data;
              default: shadow_d[word_q][7:0]  = in_data;
            endcase
            if (byte_q == LAST_BYTE) begin
              byte_d = '0;
              word_d = word_q + 1'b1;
              if (word_q == LAST_WORD) state_d = CHECKSUM;
            end else begin
              byte_d = byte_q + 1'b1;
            end
          end
        end
        CHECKSUM: begin
          if (accept) begin
            state_d = DONE;
            if (in_data == xor_q && !rsv_err_q) begin
              active_d = shadow_q;
              commit_d = 1'b1;
            end else begin
              frame_err_d = 1'b1;
            end
          end
        end
        default: state_d = IDLE;
      endcase
    end
  end

  assign cfg_valid_d = cfg_valid_q | commit_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= IDLE;
      word_q      <= '0;
      byte_q      <= '0;
      xor_q       <= '0;
      rsv_err_q   <= 1'b0;
      cfg_valid_q <= 1'b0;
      commit_q    <= 1'b0;
      frame_err_q <= 1'b0;
      for (int i = 0; i < NUM_CLAUSES; i++) active_q[i] <= '1;
    end else begin
      state_q     <= state_d;
      word_q      <= word_d;
      byte_q      <= byte_d;
      xor_q       <= xor_d;
      rsv_err_q   <= rsv_err_d;
      cfg_valid_q <= cfg_valid_d;
      commit_q    <= commit_d;
      frame_err_q <= frame_err_d;
      active_q    <= active_d;
    end
  end

  // Shadow contents only matter inside a frame, so they carry no reset.
  always_ff @(posedge clk) begin
    shadow_q <= shadow_d;
  end

  assign cfg_valid       = cfg_valid_q;
  assign commit          = commit_q;
  assign frame_err       = frame_err_q;
  assign exclude_state1  = active_q[0];
  assign exclude_state2  = active_q[1];
  assign exclude_state3  = active_q[2];
  assign exclude_state4  = active_q[3];
  assign exclude_state5  = active_q[4];
  assign exclude_state6  = active_q[5];
  assign exclude_state7  = active_q[6];
  assign exclude_state8  = active_q[7];
  assign exclude_state9  = active_q[8];
  assign exclude_state10 = active_q[9];
  assign exclude_state11 = active_q[10];
  assign exclude_state12 = active_q[11];

endmodule

// File: tb/tb_tm_exclude_loader.sv
// Self-checking bench for tm_exclude_loader: vector table, hand-written corner
// sequences and randomized frames against a frame-level reference model.
module tb_tm_exclude_loader;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [7:0]  in_data = 8'h00;
  logic        in_valid = 1'b0;
  logic        abort = 1'b0;
  logic        in_ready, cfg_valid, commit, frame_err, busy;
  logic [17:0] ex [12];

  always #5 clk = ~clk;

  tm_exclude_loader dut (
    .clk(clk), .rst_n(rst_n), .in_data(in_data), .in_valid(in_valid),
    .in_ready(in_ready), .abort(abort),
    .exclude_state1(ex[0]), .exclude_state2(ex[1]), .exclude_state3(ex[2]),
    .exclude_state4(ex[3]), .exclude_state5(ex[4]), .exclude_state6(ex[5]),
    .exclude_state7(ex[6]), .exclude_state8(ex[7]), .exclude_state9(ex[8]),
    .exclude_state10(ex[9]), .exclude_state11(ex[10]), .exclude_state12(ex[11]),
    .cfg_valid(cfg_valid), .commit(commit), .frame_err(frame_err), .busy(busy)
  );

  typedef struct {
    int pattern;   // 0: 1<<k, 1: random, 2: all zero, 3: all ones
    int rsv_word;  // word whose byte0 gets bit 2 set, -1 for none
    bit bad_ck;
    bit exp_good;
  } vec_t;

  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          commit_cnt = 0;
  int          err_cnt = 0;
  int          exp_commits = 0;
  int          commit_cyc[$];
  logic [17:0] model_bank [12];
  bit          model_cfg;
  logic [17:0] fmask [12];
  logic [7:0]  frame [38];

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (commit === 1'b1) begin
      commit_cnt++;
      commit_cyc.push_back(cyc);
    end
    if (frame_err === 1'b1) err_cnt++;
  end

  task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    if (got !== exp) begin
      fails++;
      $display("FAIL %s got=%0h exp=%0h", name, got, exp);
    end
  endtask

  task automatic model_reset();
    for (int k = 0; k < 12; k++) model_bank[k] = 18'h3FFFF;
    model_cfg = 1'b0;
  endtask

  task automatic check_bank(input string name);
    for (int k = 0; k < 12; k++)
      chk($sformatf("%s_ex%0d", name, k + 1), {14'd0, ex[k]}, {14'd0, model_bank[k]});
  endtask

  task automatic fill_masks(input int pattern);
    for (int k = 0; k < 12; k++) begin
      case (pattern)
        0:       fmask[k] = 18'h00001 << k;
        1:       fmask[k] = 18'($urandom());
        2:       fmask[k] = 18'h00000;
        default: fmask[k] = 18'h3FFFF;
      endcase
    end
  endtask

  // Serialize fmask into a frame: header, 3 bytes per word MSB first, XOR checksum.
  task automatic build(input int rsv_word, input bit bad_ck);
    logic [7:0] x;
    x = 8'h00;
    frame[0] = 8'hA5;
    for (int k = 0; k < 12; k++) begin
      frame[1 + 3*k] = {6'd0, fmask[k][17:16]} | ((k == rsv_word) ? 8'h04 : 8'h00);
      frame[2 + 3*k] = fmask[k][15:8];
      frame[3 + 3*k] = fmask[k][7:0];
    end
    for (int i = 1; i <= 36; i++) x ^= frame[i];
    frame[37] = bad_ck ? (x ^ 8'h01) : x;
  endtask

  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    in_data  = b;
    in_valid = 1'b1;
    @(negedge clk);
    while (!in_ready && n < 50) begin
      @(negedge clk);
      n++;
    end
    if (n >= 50) begin
      tests++;
      fails++;
      $display("FAIL ready_timeout got=in_ready_low exp=in_ready_high");
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
  endtask

  task automatic idle_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  // Called one step after the checksum edge, i.e. inside the DONE cycle.
  task automatic done_check(input string name, input bit exp_good, input int c0, input int e0);
    @(negedge clk);
    chk({name, "_ready_done"}, {31'd0, in_ready}, 32'd0);
    chk({name, "_busy_done"}, {31'd0, busy}, 32'd1);
    chk({name, "_commit"}, {31'd0, commit}, {31'd0, exp_good});
    chk({name, "_frame_err"}, {31'd0, frame_err}, {31'd0, !exp_good});
    if (exp_good) begin
      for (int k = 0; k < 12; k++) model_bank[k] = fmask[k];
      model_cfg = 1'b1;
      exp_commits++;
    end
    check_bank(name);
    chk({name, "_cfg_valid"}, {31'd0, cfg_valid}, {31'd0, model_cfg});
    @(posedge clk);
    #1;
    @(negedge clk);
    chk({name, "_pulse_end"}, {30'd0, commit, frame_err}, 32'd0);
    chk({name, "_busy_idle"}, {31'd0, busy}, 32'd0);
    @(posedge clk);
    #1;
    chk({name, "_commit_cnt"}, commit_cnt - c0, {31'd0, exp_good});
    chk({name, "_err_cnt"}, err_cnt - e0, {31'd0, !exp_good});
  endtask

  task automatic run_frame(input string name, input int rsv, input bit bad, input bit exp_good,
                           input bit gaps);
    int c0, e0;
    c0 = commit_cnt;
    e0 = err_cnt;
    build(rsv, bad);
    if (gaps) send_byte(8'h3C);
    for (int i = 0; i < 38; i++) begin
      send_byte(frame[i]);
      if (gaps && i < 37) idle_cycles($urandom_range(0, 2));
    end
    done_check(name, exp_good, c0, e0);
    $display("[TB] frame %s rsv=%0d bad_ck=%0d expect_commit=%0d ex1=%05h", name, rsv, bad,
             exp_good, ex[0]);
  endtask

  vec_t vt [6];

  initial begin
    int c0, e0, low_cnt, cycles, idx, nc;
    logic [7:0]  stream [76];
    logic [17:0] fa [12];
    bit r;

    vt[0] = '{0, -1, 1'b1, 1'b0};
    vt[1] = '{0, -1, 1'b0, 1'b1};
    vt[2] = '{2,  5, 1'b0, 1'b0};
    vt[3] = '{1, -1, 1'b0, 1'b1};
    vt[4] = '{2, -1, 1'b0, 1'b1};
    vt[5] = '{3,  0, 1'b1, 1'b0};

    model_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_in_ready", {31'd0, in_ready}, 32'd1);
    chk("rst_busy", {31'd0, busy}, 32'd0);
    chk("rst_flags", {29'd0, cfg_valid, commit, frame_err}, 32'd0);
    check_bank("rst");
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle_cycles(2);

    for (int i = 0; i < 6; i++) begin
      fill_masks(vt[i].pattern);
      run_frame($sformatf("vec%0d", i), vt[i].rsv_word, vt[i].bad_ck, vt[i].exp_good, i[0]);
      if (i == 1) begin
        chk("vec1_ex1_const", {14'd0, ex[0]}, 32'h00001);
        chk("vec1_ex12_const", {14'd0, ex[11]}, 32'h00800);
      end
    end

    // Abort mid-payload: the byte presented with abort is dropped, frame 1 stays active.
    fill_masks(1);
    run_frame("abort_f1", -1, 1'b0, 1'b1, 1'b0);
    c0 = commit_cnt;
    e0 = err_cnt;
    fill_masks(1);
    build(-1, 1'b0);
    for (int i = 0; i <= 20; i++) send_byte(frame[i]);
    in_data = frame[21];
    in_valid = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    in_valid = 1'b0;
    @(negedge clk);
    chk("abort_busy", {31'd0, busy}, 32'd0);
    send_byte(8'h00);
    send_byte(8'h5A);
    idle_cycles(3);
    chk("abort_busy_after_garbage", {31'd0, busy}, 32'd0);
    check_bank("abort");
    chk("abort_no_commit", commit_cnt - c0, 32'd0);
    chk("abort_no_err", err_cnt - e0, 32'd0);
    $display("[TB] abort at payload byte 20, garbage 00 5A dropped");

    // Abort coinciding with the checksum byte must not commit.
    for (int i = 0; i < 37; i++) send_byte(frame[i]);
    in_data = frame[37];
    in_valid = 1'b1;
    abort = 1'b1;
    @(posedge clk);
    #1;
    abort = 1'b0;
    in_valid = 1'b0;
    idle_cycles(3);
    check_bank("abort_ck");
    chk("abort_ck_no_commit", commit_cnt - c0, 32'd0);
    chk("abort_ck_no_err", err_cnt - e0, 32'd0);
    $display("[TB] abort on checksum byte, no commit");

    // Back-to-back frames with in_valid held high.
    fill_masks(1);
    build(-1, 1'b0);
    for (int i = 0; i < 38; i++) stream[i] = frame[i];
    fill_masks(1);
    build(-1, 1'b0);
    for (int i = 0; i < 38; i++) stream[38 + i] = frame[i];
    c0 = commit_cnt;
    e0 = err_cnt;
    nc = commit_cyc.size();
    low_cnt = 0;
    cycles = 0;
    idx = 0;
    in_valid = 1'b1;
    while (idx < 76 && cycles < 300) begin
      in_data = stream[idx];
      @(negedge clk);
      r = in_ready;
      if (!r) low_cnt++;
      @(posedge clk);
      #1;
      if (r) idx++;
      cycles++;
    end
    in_valid = 1'b0;
    chk("b2b_all_bytes", idx, 32'd76);
    exp_commits++;
    done_check("b2b", 1'b1, c0 + 1, e0);
    chk("b2b_ready_low", low_cnt, 32'd1);
    chk("b2b_commits", commit_cyc.size() - nc, 32'd2);
    if (commit_cyc.size() - nc == 2)
      chk("b2b_spacing", commit_cyc[nc + 1] - commit_cyc[nc], 32'd39);
    $display("[TB] back-to-back frames, ready_low=%0d", low_cnt);

    // Asynchronous reset in the middle of a frame.
    fill_masks(1);
    build(-1, 1'b0);
    for (int i = 0; i <= 30; i++) send_byte(frame[i]);
    rst_n = 1'b0;
    #1;
    model_reset();
    check_bank("midrst");
    chk("midrst_flags", {29'd0, cfg_valid, commit, frame_err}, 32'd0);
    chk("midrst_busy", {31'd0, busy}, 32'd0);
    chk("midrst_ready", {31'd0, in_ready}, 32'd1);
    @(posedge clk);
    #1;
    rst_n = 1'b1;
    idle_cycles(2);
    $display("[TB] reset at payload byte 30");
    fill_masks(1);
    run_frame("post_rst", -1, 1'b0, 1'b1, 1'b0);

    // Randomized frames: a frame is good iff its checksum matches and no reserved bit is set.
    for (int n = 0; n < 24; n++) begin
      int roll, rsv;
      bit bad;
      roll = $urandom_range(0, 5);
      rsv  = (roll == 0) ? int'($urandom_range(0, 11)) : -1;
      bad  = (roll == 1);
      fill_masks(1);
      run_frame($sformatf("rand%0d", n), rsv, bad, (rsv < 0) && !bad, 1'b1);
    end

    chk("total_commits", commit_cnt, exp_commits);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/tm_exclude_loader.md
# tm_exclude_loader

Configuration writer for the Tsetlin-machine inference datapath: accepts a byte stream carrying the 12 clause exclude masks (18 bits each, 3 classes × 4 clauses), checks it, and drives the `exclude_state1`..`exclude_state12` inputs of the inference block. Frames are assembled in a shadow bank and committed atomically, so the inference engine never sees a partially loaded model. The block sits between the host/UART byte interface and the inference engine.

## Interface
Parameters:
- `NUM_CLAUSES`, 12: masks per frame; fixed for the Iris model.
- `MASK_W`, 18: bits per mask, 9 features plus 9 negated literals.
- `HEADER`, 8'hA5: frame start byte.

Ports:
- `clk`  in  1  single clock, rising edge.
- `rst_n`  in  1  asynchronous, active-low reset.
- `in_data`  in  8  stream byte.
- `in_valid`  in  1  byte present.
- `in_ready`  out  1  byte accepted when `in_valid && in_ready`.
- `abort`  in  1  synchronous; drops the frame in progress.
- `exclude_state1`..`exclude_state12`  out  18 each  active masks, registered.
- `cfg_valid`  out  1  sticky; at least one frame committed since reset.
- `commit`  out  1  one-cycle pulse: the active bank was updated.
- `frame_err`  out  1  one-cycle pulse: the frame was rejected.
- `busy`  out  1  the FSM is not in IDLE.

## Operation
- Frame: `HEADER`, then 36 payload bytes (word k = 0..11 maps to `exclude_state(k+1)`), then 1 checksum byte.
- Word byte order, MSB first:
  - byte0[1:0] = mask[17:16]; byte0[7:2] are reserved and must be 0.
  - byte1 = mask[15:8].
  - byte2 = mask[7:0].
- Mask bits pass through unaltered; literal ordering is owned by the inference block.
- Checksum: XOR of the 36 payload bytes; the header is excluded.
- FSM states:
  - IDLE: `in_ready` = 1. `HEADER` → PAYLOAD, clearing the byte counter, running XOR and reserved-error flag. Any other byte is discarded silently.
  - PAYLOAD: `in_ready` = 1. Each accepted byte:
    - is written to shadow word `cnt/3`, byte `cnt%3`;
    - is XORed into the running checksum;
    - if `cnt%3 == 0` and bits [7:2] ≠ 0, sets the sticky reserved-error flag.
    - `cnt` counts 0..35; acceptance at `cnt == 35` → CHECKSUM.
  - CHECKSUM: `in_ready` = 1. Accepting one byte → DONE. At that same edge, if byte == running XOR and the reserved flag is clear, the active bank ← shadow bank (all 12 masks in the same edge).
  - DONE: `in_ready` = 0 for exactly one cycle. `commit` = 1 on a good frame; otherwise `frame_err` = 1. Then → IDLE.
- A header byte received inside PAYLOAD or CHECKSUM is treated as data (no resync).
- `abort` sampled high in any state: → IDLE next edge; the shadow bank is discarded, the active bank is unchanged, no pulse. A byte accepted in the same cycle as `abort` is dropped. `abort` wins over a checksum acceptance, so no commit occurs.
- The active bank changes only on commit; the shadow contents are don't-care outside a frame.

## Timing
- Reset values (asynchronous, `rst_n` low):
  - state IDLE; `in_ready` 1, `busy` 0;
  - all `exclude_stateN` = 18'h3FFFF (all literals excluded);
  - `cfg_valid` 0, `commit` 0, `frame_err` 0.
- Reset mid-frame: all of the above values, the active bank is back to 18'h3FFFF, and `cfg_valid` returns to 0.
- Latency: the new masks appear on `exclude_stateN` in the cycle after the checksum byte is accepted. `commit` is high in that same cycle; `cfg_valid` rises there on the first commit.
- Minimum frame period is 39 cycles (38 accepted bytes + 1 DONE cycle). Back-to-back frames with `in_valid` held high lose no bytes, because `in_ready` stalls them during DONE.
- `in_ready` depends only on the state (a registered decode); it has no combinational path from `in_valid`.
- `busy` is 1 in PAYLOAD, CHECKSUM and DONE.

## Structure
- Shared package `tm_cfg_pkg`:
  - constants `NUM_CLAUSES`, `MASK_W`, `HEADER`, `BYTES_PER_WORD` = 3, `PAYLOAD_BYTES` = 36;
  - state enum {IDLE, PAYLOAD, CHECKSUM, DONE}.
- Single module; shadow and active banks are 12×18 register arrays.
- No sub-module is needed. The byte-to-word assembly is an inline counter/demux.
- The 12 active words are fanned out to the named output ports at the top of the module.

## Test plan
- Good frame: A5, masks k→18'h00001<<k, correct XOR → `exclude_state1` = 18'h00001, `exclude_state12` = 18'h00800; `commit` is one cycle; `cfg_valid` = 1.
- Bad checksum: same frame with checksum ^ 8'h01 → `frame_err` pulse; outputs stay 18'h3FFFF; `cfg_valid` = 0.
- Reserved bits: byte0 of word 5 = 8'h04 with a correct XOR → `frame_err`; the active bank is unchanged.
- Abort mid-frame: good frame 1 loaded, then frame 2 aborted at byte 20, then garbage 8'h00 and 8'h5A → outputs still hold frame 1; no pulse; `busy` is 0 one cycle after `abort`.
- Back-to-back: two good frames with `in_valid` held high → `in_ready` low exactly one cycle between them; two `commit` pulses 39 cycles apart; outputs hold frame 2.
- Reset at byte 30 of the second frame → all outputs 18'h3FFFF; `cfg_valid` 0; a following good frame commits normally.
